wb_l3: RTL and testbench
========================

WB_L3 -- requirements
Module: wb_l3

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, load-response watchdog limit in cycles, used only when WB_LOAD_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 valid_l2  input  1  L2 holds a retiring instruction.
REQ-005 rd_l2  input  5  destination register of the L2 instruction.
REQ-006 we_l2  input  1  the L2 instruction writes rd.
REQ-007 is_load_l2  input  1  the L2 instruction is a load; alu_res_l2 is its byte address.
REQ-008 funct3_l2  input  3  load size and sign code.
REQ-009 alu_res_l2  input  32  ALU result, or load address.
REQ-010 dmem_rdata  input  32  data-memory read word.
REQ-011 dmem_rvalid  input  1  dmem_rdata is valid this cycle.
REQ-012 rd_l3  output  5  L3 destination register; 0 when L3 writes nothing.
REQ-013 wval_l3  output  32  L3 write-back value; goes to the forwarding path and the register file.
REQ-014 reg_we_l3  output  1  register-file write enable.
REQ-015 stall_l2  output  1  hold L2 while a load is outstanding.
REQ-016 load_err_l3  output  1  a load timed out.

Function
REQ-017 The FSM SHALL have two states: IDLE and WAIT_LOAD.
REQ-018 In IDLE, when valid_l2=1 and is_load_l2=0, the block SHALL, at the next edge:
- load rd_l3 with rd_l2, or with 0 if we_l2=0;
- load wval_l3 with alu_res_l2;
- give one cycle of latency from L2 to L3.
REQ-019 In IDLE, when valid_l2=0, the next edge SHALL set rd_l3=0 and hold wval_l3.
REQ-020 In IDLE, when valid_l2=1 and is_load_l2=1, the next edge SHALL:
- latch the effective rd (rd_l2, or 0 if we_l2=0), funct3_l2 and alu_res_l2[1:0];
- set rd_l3=0;
- move to WAIT_LOAD.
REQ-021 stall_l2 SHALL be 1 exactly while in WAIT_LOAD, including the cycle in which dmem_rvalid arrives, so the dependent L2 instruction sees the load result forwarded from L3.
REQ-022 In WAIT_LOAD, all L2 inputs SHALL be ignored.
REQ-023 In WAIT_LOAD, when dmem_rvalid=1, the next edge SHALL:
- load wval_l3 with the extracted load value;
- load rd_l3 with the latched rd;
- return to IDLE.
REQ-024 Load extraction SHALL select bytes and halfwords from dmem_rdata as follows:
- byte lane = offset[1:0];
- halfword lane = offset[1]; offset[0] is ignored;
- 000 LB: sign-extend the byte;
- 100 LBU: zero-extend the byte;
- 001 LH: sign-extend the halfword;
- 101 LHU: zero-extend the halfword;
- 010 and all other codes: the full word.
REQ-025 reg_we_l3 SHALL equal (rd_l3 != 0) combinationally, so x0 is never written and never matches in forwarding.
REQ-026 dmem_rvalid asserted in IDLE SHALL be ignored.
REQ-027 A late response arriving after reset SHALL NOT write any register.

Reset
REQ-028 While rst=1, the next edge SHALL set the state to IDLE and clear all latched load fields.
REQ-029 While rst=1, the next edge SHALL set rd_l3=0, wval_l3=0 and load_err_l3=0, so reg_we_l3=0 and stall_l2=0.
REQ-030 rst SHALL override every other input, including while in WAIT_LOAD.

Configuration
REQ-031 The macro WB_LOAD_TIMEOUT_EN SHALL select the load-timeout feature.
REQ-032 With WB_LOAD_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT_LOAD and increment each WAIT_LOAD cycle without dmem_rvalid;
- if it reaches TIMEOUT_CYCLES before dmem_rvalid, the next edge SHALL return to IDLE with rd_l3=0 and wval_l3=0 and pulse load_err_l3 for exactly one cycle;
- if dmem_rvalid and timeout coincide, dmem_rvalid SHALL win.
REQ-033 Without WB_LOAD_TIMEOUT_EN:
- load_err_l3 SHALL be tied to 0 and no counter logic SHALL be present;
- WAIT_LOAD SHALL persist until dmem_rvalid or rst.

Verification
REQ-034 ALU op: rd_l2=5, we_l2=1, alu_res_l2=0x1234_5678 -> next cycle rd_l3=5, wval_l3=0x1234_5678, reg_we_l3=1, stall_l2=0.
REQ-035 x0 and no-write cases:
- rd_l2=0, we_l2=1 -> rd_l3=0, reg_we_l3=0;
- rd_l2=7, we_l2=0 -> rd_l3=0, reg_we_l3=0.
REQ-036 LB, funct3=000, addr offset 3, rvalid 3 cycles later with dmem_rdata=0x80FF_0011 -> stall_l2=1 for 3 cycles, then rd_l3=rd, wval_l3=0xFFFF_FF80.
REQ-037 LHU, funct3=101, offset 2, dmem_rdata=0x8001_7FFF -> wval_l3=0x0000_8001.
REQ-038 rst during WAIT_LOAD, then dmem_rvalid one cycle later -> IDLE, stall_l2=0, rd_l3=0, no write.
REQ-039 With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16, no rvalid -> after 16 stall cycles, load_err_l3=1 for one cycle, rd_l3=0, stall_l2=0.

Source files
------------

// File: rtl/wb_l3_if.sv
// Bus bundle between the L2 stage / data memory and the L3 write-back stage.
// The master drives the L2 and data-memory inputs; the slave is wb_l3.
interface wb_l3_if;
  logic        valid_l2;
  logic [4:0]  rd_l2;
  logic        we_l2;
  logic        is_load_l2;
  logic [2:0]  funct3_l2;
  logic [31:0] alu_res_l2;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [4:0]  rd_l3;
  logic [31:0] wval_l3;
  logic        reg_we_l3;
  logic        stall_l2;
  logic        load_err_l3;

  modport master (
    output valid_l2, rd_l2, we_l2, is_load_l2, funct3_l2, alu_res_l2,
    output dmem_rdata, dmem_rvalid,
    input  rd_l3, wval_l3, reg_we_l3, stall_l2, load_err_l3
  );

  modport slave (
    input  valid_l2, rd_l2, we_l2, is_load_l2, funct3_l2, alu_res_l2,
    input  dmem_rdata, dmem_rvalid,
    output rd_l3, wval_l3, reg_we_l3, stall_l2, load_err_l3
  );
endinterface

// File: rtl/wb_l3.sv
// L3 write-back stage: registers ALU results, holds L2 while a load is outstanding.
// Optional load-response watchdog enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_l3 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic   clk,
  input logic   rst,
  wb_l3_if.slave bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_l3: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q;
  logic [4:0]  rd_q;
  logic [31:0] wval_q;
  logic        stall_q;
  logic        err_q;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;

  logic [4:0]  eff_rd;
  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;

  assign eff_rd = bus.we_l2 ? bus.rd_l2 : 5'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = bus.dmem_rdata[8*gi +: 8];
  end

  // Halfword lane comes from offset[1] only; misaligned offset[0] is dropped.
  assign sel_byte = lane_byte[ld_off_q];
  assign sel_half = ld_off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  always_comb begin
    load_val = bus.dmem_rdata;
    case (ld_f3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = bus.dmem_rdata;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= 5'd0;
      wval_q   <= 32'd0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      ld_rd_q  <= 5'd0;
      ld_f3_q  <= 3'd0;
      ld_off_q <= 2'd0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid_l2) begin
            if (bus.is_load_l2) begin
              ld_rd_q  <= eff_rd;
              ld_f3_q  <= bus.funct3_l2;
              ld_off_q <= bus.alu_res_l2[1:0];
              rd_q     <= 5'd0;
              stall_q  <= 1'b1;
              state_q  <= WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end else begin
              rd_q   <= eff_rd;
              wval_q <= bus.alu_res_l2;
            end
          end else begin
            rd_q <= 5'd0;
          end
        end
        WAIT_LOAD: begin
          // A response on the watchdog's final cycle still completes the load.
          if (bus.dmem_rvalid) begin
            rd_q    <= ld_rd_q;
            wval_q  <= load_val;
            stall_q <= 1'b0;
            state_q <= IDLE;
`ifdef WB_LOAD_TIMEOUT_EN
          end else if (timeout_hit) begin
            rd_q    <= 5'd0;
            wval_q  <= 32'd0;
            err_q   <= 1'b1;
            stall_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_l3     = rd_q;
  assign bus.wval_l3   = wval_q;
  assign bus.reg_we_l3 = (rd_q != 5'd0);
  assign bus.stall_l2  = stall_q;
`ifdef WB_LOAD_TIMEOUT_EN
  assign bus.load_err_l3 = err_q;
`else
  assign bus.load_err_l3 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_l3.sv
// Randomised bench for wb_l3 against a transaction-level reference model,
// preceded by directed cases for ALU, x0, LB, LHU, reset-during-load and timeout.
module tb_wb_l3;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_l3_if bus();

  wb_l3 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: one outstanding load at most, expected L3 outputs.
  bit          m_busy;
  logic [4:0]  m_rd;
  logic [31:0] m_wval;
  bit          m_err;
  logic [4:0]  m_prd;
  logic [2:0]  m_pf3;
  logic [1:0]  m_poff;
  int          m_waited;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_rd = 0; m_wval = 0; m_err = 0; m_waited = 0;
    end else if (m_busy) begin
      m_err = 0;
      if (bus.dmem_rvalid) begin
        m_rd   = m_prd;
        m_wval = extract(bus.dmem_rdata, m_pf3, m_poff);
        m_busy = 0;
        n_txn++;
        $display("txn %0d: load rd=%0d f3=%b off=%0d rdata=%h -> %h",
                 n_txn, m_prd, m_pf3, m_poff, bus.dmem_rdata, m_wval);
      end else begin
        m_waited++;
`ifdef WB_LOAD_TIMEOUT_EN
        if (m_waited == TO) begin
          m_busy = 0; m_rd = 0; m_wval = 0; m_err = 1;
          n_txn++;
          $display("txn %0d: load rd=%0d timed out after %0d cycles", n_txn, m_prd, m_waited);
        end
`endif
      end
    end else begin
      m_err = 0;
      if (bus.valid_l2) begin
        if (bus.is_load_l2) begin
          m_busy   = 1;
          m_prd    = bus.we_l2 ? bus.rd_l2 : 5'd0;
          m_pf3    = bus.funct3_l2;
          m_poff   = bus.alu_res_l2[1:0];
          m_rd     = 0;
          m_waited = 0;
        end else begin
          m_rd   = bus.we_l2 ? bus.rd_l2 : 5'd0;
          m_wval = bus.alu_res_l2;
          n_txn++;
          $display("txn %0d: alu rd=%0d we=%0b val=%h", n_txn, bus.rd_l2, bus.we_l2, m_wval);
        end
      end else begin
        m_rd = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("rd_l3",       bus.rd_l3,       m_rd);
    check_eq("wval_l3",     bus.wval_l3,     m_wval);
    check_eq("reg_we_l3",   bus.reg_we_l3,   m_rd != 5'd0);
    check_eq("stall_l2",    bus.stall_l2,    m_busy);
    check_eq("load_err_l3", bus.load_err_l3, m_err);
  endtask

  task automatic idle_inputs();
    bus.valid_l2    = 0;
    bus.rd_l2       = 0;
    bus.we_l2       = 0;
    bus.is_load_l2  = 0;
    bus.funct3_l2   = 0;
    bus.alu_res_l2  = 0;
    bus.dmem_rdata  = 0;
    bus.dmem_rvalid = 0;
  endtask

  task automatic drive_l2(input bit ld, input logic [4:0] rd, input bit we,
                          input logic [2:0] f3, input logic [31:0] alu);
    bus.valid_l2   = 1;
    bus.is_load_l2 = ld;
    bus.rd_l2      = rd;
    bus.we_l2      = we;
    bus.funct3_l2  = f3;
    bus.alu_res_l2 = alu;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    tick();
    check_eq("rst_rd",    bus.rd_l3,    32'd0);
    check_eq("rst_wval",  bus.wval_l3,  32'd0);
    check_eq("rst_stall", bus.stall_l2, 32'd0);
    rst = 0;

    // ALU write
    drive_l2(0, 5'd5, 1, 3'd0, 32'h1234_5678);
    tick();
    check_eq("alu_rd",    bus.rd_l3,     32'd5);
    check_eq("alu_wval",  bus.wval_l3,   32'h1234_5678);
    check_eq("alu_we",    bus.reg_we_l3, 32'd1);
    check_eq("alu_stall", bus.stall_l2,  32'd0);

    // x0 and no-write
    drive_l2(0, 5'd0, 1, 3'd0, 32'hAAAA_0001);
    tick();
    check_eq("x0_we", bus.reg_we_l3, 32'd0);
    drive_l2(0, 5'd7, 0, 3'd0, 32'hAAAA_0002);
    tick();
    check_eq("nowe_rd", bus.rd_l3,     32'd0);
    check_eq("nowe_we", bus.reg_we_l3, 32'd0);

    // LB offset 3, response during the third stall cycle; L2 junk must be ignored
    drive_l2(1, 5'd9, 1, 3'b000, 32'h1000_0003);
    tick();
    check_eq("lb_stall1", bus.stall_l2, 32'd1);
    drive_l2(0, 5'd3, 1, 3'd0, 32'hDEAD_BEEF);
    tick();
    check_eq("lb_stall2", bus.stall_l2, 32'd1);
    tick();
    check_eq("lb_stall3", bus.stall_l2, 32'd1);
    check_eq("lb_rd_wait", bus.rd_l3,   32'd0);
    bus.dmem_rvalid = 1;
    bus.dmem_rdata  = 32'h80FF_0011;
    tick();
    check_eq("lb_stall_done", bus.stall_l2, 32'd0);
    check_eq("lb_rd",   bus.rd_l3,   32'd9);
    check_eq("lb_wval", bus.wval_l3, 32'hFFFF_FF80);
    idle_inputs();
    tick();

    // LHU offset 2
    drive_l2(1, 5'd12, 1, 3'b101, 32'h2000_0002);
    tick();
    idle_inputs();
    bus.dmem_rvalid = 1;
    bus.dmem_rdata  = 32'h8001_7FFF;
    tick();
    check_eq("lhu_rd",   bus.rd_l3,   32'd12);
    check_eq("lhu_wval", bus.wval_l3, 32'h0000_8001);
    idle_inputs();
    tick();

    // Reset while waiting, late response must not write
    drive_l2(1, 5'd4, 1, 3'b010, 32'h3000_0000);
    tick();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    bus.dmem_rvalid = 1;
    bus.dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    check_eq("late_stall", bus.stall_l2,  32'd0);
    check_eq("late_rd",    bus.rd_l3,     32'd0);
    check_eq("late_we",    bus.reg_we_l3, 32'd0);
    idle_inputs();
    tick();

`ifdef WB_LOAD_TIMEOUT_EN
    drive_l2(1, 5'd6, 1, 3'b010, 32'h4000_0000);
    tick();
    idle_inputs();
    check_eq("to_stall_0", bus.stall_l2, 32'd1);
    for (int i = 1; i < TO; i++) begin
      tick();
      check_eq("to_stall", bus.stall_l2, 32'd1);
    end
    tick();
    check_eq("to_err",      bus.load_err_l3, 32'd1);
    check_eq("to_rd",       bus.rd_l3,       32'd0);
    check_eq("to_wval",     bus.wval_l3,     32'd0);
    check_eq("to_stall_end", bus.stall_l2,   32'd0);
    tick();
    check_eq("to_err_pulse", bus.load_err_l3, 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rst             = ($urandom_range(0, 59) == 0);
      bus.valid_l2    = ($urandom_range(0, 3) != 0);
      bus.is_load_l2  = ($urandom_range(0, 2) == 0);
      bus.rd_l2       = 5'($urandom_range(0, 31));
      bus.we_l2       = ($urandom_range(0, 4) != 0);
      bus.funct3_l2   = 3'($urandom_range(0, 7));
      bus.alu_res_l2  = $urandom;
      bus.dmem_rdata  = $urandom;
`ifdef WB_LOAD_TIMEOUT_EN
      bus.dmem_rvalid = ($urandom_range(0, 11) == 0);
`else
      bus.dmem_rvalid = ($urandom_range(0, 2) == 0);
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
